// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irrigation_sequencer
// Purpose  : Tank-fill and watering sequencer for one irrigation zone. It
//            refills the tank when the water is below the mid probe and waters
//            the soil on demand. The watering method (dripper or sprinkler) is
//            chosen when the run starts and held until the run ends. Every run
//            is followed by a forced cool-down. Inconsistent probe readings and
//            fill timeouts latch a fault that needs an operator acknowledge.
// Ports    : clk           - system clock, rising edge active
//            reset         - asynchronous active-high reset
//            low/mid/high  - tank probes, 1 = water at or above the probe
//            Us, Ua, T     - soil dry request, air humidity high, temp high
//            ack           - operator fault acknowledge
//            watter_supply - tank fill valve
//            asp, got      - sprinkler valve, dripper valve
//            error, alarme - fault indication and audible alarm
//            state         - state code: IDLE=0 FILL=1 IRRIGATE=2 COOLDOWN=3 FAULT=4
// Revision : 1.0 - initial release
// ============================================================================
module irrigation_sequencer #(
    parameter int FILL_TIMEOUT = 16,  // 1..255
    parameter int IRR_MAX      = 32,  // 1..255
    parameter int COOL_CYCLES  = 4,   // 1..255
    parameter int FAULT_FILTER = 2    // 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       low,
    input  logic       mid,
    input  logic       high,
    input  logic       Us,
    input  logic       Ua,
    input  logic       T,
    input  logic       ack,
    output logic       watter_supply,
    output logic       asp,
    output logic       got,
    output logic       error,
    output logic       alarme,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_IRRIGATE = 3'd2,
        S_COOLDOWN = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] c_fill_last = 8'(FILL_TIMEOUT - 1);
    localparam logic [7:0] c_irr_last  = 8'(IRR_MAX - 1);
    localparam logic [7:0] c_cool_last = 8'(COOL_CYCLES - 1);
    localparam logic [7:0] c_filter    = 8'(FAULT_FILTER);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;      // cycles spent in the current state
    logic [7:0] r_filt;     // consecutive inconsistent-probe cycles
    logic [7:0] w_filt_next;
    logic       r_drip;     // latched method: 1 = dripper, 0 = sprinkler
    logic       w_incons;
    logic       w_fault;

    // A probe reading water above a probe that reads dry is physically impossible.
    assign w_incons = (mid & ~low) | (high & ~mid);

    // The fault fires on the edge where the count including the current
    // cycle reaches the threshold, so a single glitch cycle is always ignored
    // when the threshold is 2 or more.
    always_comb begin
        w_filt_next = 8'd0;
        if (w_incons) begin
            w_filt_next = (r_filt == c_filter) ? r_filt : r_filt + 8'd1;
        end
    end

    assign w_fault = w_incons && (w_filt_next == c_filter);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fault)      w_next = S_FAULT;
                else if (!mid)    w_next = S_FILL;
                else if (Us)      w_next = S_IRRIGATE;
            end
            S_FILL: begin
                if (w_fault)                  w_next = S_FAULT;
                else if (high)                w_next = S_IDLE;
                else if (r_cnt == c_fill_last) w_next = S_FAULT;
            end
            S_IRRIGATE: begin
                if (w_fault)                        w_next = S_FAULT;
                else if (!mid)                      w_next = S_FILL;
                else if (!Us || r_cnt == c_irr_last) w_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (w_fault)                  w_next = S_FAULT;
                else if (r_cnt == c_cool_last) w_next = S_IDLE;
            end
            S_FAULT: begin
                if (ack && !w_incons) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_filt  <= 8'd0;
            r_drip  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_filt  <= w_filt_next;
            if (w_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Method is sampled only on run entry; an aborted run forgets it.
            if (w_next == S_IRRIGATE && r_state != S_IRRIGATE) begin
                r_drip <= T | ~Ua;
            end else if (w_next != S_IRRIGATE) begin
                r_drip <= 1'b0;
            end
        end
    end

    // Pure decode of the state register: the asynchronous reset of r_state
    // closes every valve immediately without waiting for a clock.
    assign watter_supply = (r_state == S_FILL);
    assign asp           = (r_state == S_IRRIGATE) & ~r_drip;
    assign got           = (r_state == S_IRRIGATE) &  r_drip;
    assign error         = (r_state == S_FAULT);
    assign alarme        = (r_state == S_FAULT);
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irrigation_sequencer
// Purpose  : Self-checking bench for irrigation_sequencer. Directed scenarios
//            (refill, fill timeout, method select, run limits, sensor filter,
//            abort and reset) are followed by a randomized phase. Every
//            clock is compared against a behavioural model of the sequencing
//            rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irrigation_sequencer;

    localparam int FT = 16;
    localparam int IM = 32;
    localparam int CC = 4;
    localparam int FF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       low, mid, high, Us, Ua, T, ack;
    logic       watter_supply, asp, got, error, alarme;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase number (0 idle, 1 fill, 2 irrigate, 3 cooldown, 4 fault),
    // time spent in the phase, current bad-probe streak, dripper chosen.
    int m_phase;
    int m_time;
    int m_streak;
    bit m_drip;

    irrigation_sequencer #(
        .FILL_TIMEOUT (FT),
        .IRR_MAX      (IM),
        .COOL_CYCLES  (CC),
        .FAULT_FILTER (FF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .low           (low),
        .mid           (mid),
        .high          (high),
        .Us            (Us),
        .Ua            (Ua),
        .T             (T),
        .ack           (ack),
        .watter_supply (watter_supply),
        .asp           (asp),
        .got           (got),
        .error         (error),
        .alarme        (alarme),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase  = 0;
        m_time   = 0;
        m_streak = 0;
        m_drip   = 1'b0;
    endfunction

    // One clock edge worth of sequencing rules, evaluated on the inputs
    // that are stable across the edge.
    function automatic void model_edge();
        bit bad;
        bit flt;
        int nxt;
        bad      = (mid && !low) || (high && !mid);
        m_streak = bad ? ((m_streak + 1 > FF) ? FF : m_streak + 1) : 0;
        flt      = bad && (m_streak >= FF);
        nxt      = m_phase;
        if (m_phase == 4) begin
            if (ack && !bad) nxt = 0;
        end else if (flt) begin
            nxt = 4;
        end else if (m_phase == 0) begin
            if (!mid)    nxt = 1;
            else if (Us) nxt = 2;
        end else if (m_phase == 1) begin
            if (high)                nxt = 0;
            else if (m_time >= FT - 1) nxt = 4;
        end else if (m_phase == 2) begin
            if (!mid)                       nxt = 1;
            else if (!Us || m_time >= IM - 1) nxt = 3;
        end else begin
            if (m_time >= CC - 1) nxt = 0;
        end
        if (nxt == 2 && m_phase != 2) m_drip = T || !Ua;
        m_time  = (nxt == m_phase) ? m_time + 1 : 0;
        m_phase = nxt;
    endfunction

    task automatic check_all();
        bit irr;
        irr = (m_phase == 2);
        check("state",         8'(state),         8'(m_phase));
        check("watter_supply", 8'(watter_supply), 8'(m_phase == 1));
        check("asp",           8'(asp),           8'(irr && !m_drip));
        check("got",           8'(got),           8'(irr && m_drip));
        check("error",         8'(error),         8'(m_phase == 4));
        check("alarme",        8'(alarme),        8'(m_phase == 4));
        check("asp_got_excl",  8'(asp & got),     8'd0);
        check("fill_vs_irr",   8'(watter_supply & (asp | got)), 8'd0);
    endtask

    // Inputs change only at the falling edge, after tick returns.
    task automatic tick();
        if (reset) model_reset();
        else       model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_tank(input logic l, input logic m, input logic h);
        low  = l;
        mid  = m;
        high = h;
    endtask

    initial begin
        int n;
        int lvl;
        reset = 1'b1;
        Us = 1'b0; Ua = 1'b0; T = 1'b0; ack = 1'b0;
        set_tank(1'b1, 1'b1, 1'b0);
        model_reset();
        @(negedge clk);
        check_all();
        check("reset_state", 8'(state), 8'd0);
        tick();
        reset = 1'b0;

        // Refill: dry at mid, fill, tank reaches high on the fifth fill cycle.
        set_tank(1'b1, 1'b0, 1'b0);
        tick();
        check("refill_ws_on", 8'(watter_supply), 8'd1);
        repeat (4) tick();
        set_tank(1'b1, 1'b1, 1'b1);
        tick();
        check("refill_done_state", 8'(state), 8'd0);
        check("refill_ws_off", 8'(watter_supply), 8'd0);
        set_tank(1'b1, 1'b1, 1'b0);
        tick();

        // Fill timeout followed by acknowledge.
        set_tank(1'b1, 1'b0, 1'b0);
        tick();
        n = 0;
        while (state == 3'd1 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_fill_cycles", 8'(n), 8'd16);
        check("timeout_error", 8'(error), 8'd1);
        check("timeout_alarme", 8'(alarme), 8'd1);
        set_tank(1'b1, 1'b1, 1'b0);
        ack = 1'b1;
        tick();
        check("ack_to_idle", 8'(state), 8'd0);
        ack = 1'b0;

        // Method select: dripper when hot, held while T changes.
        Us = 1'b1; T = 1'b1; Ua = 1'b0;
        tick();
        check("drip_got", 8'(got), 8'd1);
        check("drip_asp", 8'(asp), 8'd0);
        T = 1'b0; Ua = 1'b1;
        tick();
        check("drip_held", 8'(got), 8'd1);
        Us = 1'b0;
        tick();
        repeat (4) tick();
        check("cool_back_idle", 8'(state), 8'd0);
        Us = 1'b1;
        tick();
        check("sprink_asp", 8'(asp), 8'd1);
        T = 1'b1;
        tick();
        check("sprink_held", 8'(asp), 8'd1);
        Us = 1'b0;
        tick();
        repeat (4) tick();

        // Run limits with demand held continuously.
        Us = 1'b1;
        tick();
        n = 0;
        while (state == 3'd2 && n < 100) begin
            tick();
            n++;
        end
        check("irr_run_cycles", 8'(n), 8'd32);
        n = 0;
        while (state == 3'd3 && n < 100) begin
            check("cool_valves", 8'({watter_supply, asp, got}), 8'd0);
            tick();
            n++;
        end
        check("cool_cycles", 8'(n), 8'd4);
        tick();
        check("irr_again", 8'(state), 8'd2);
        Us = 1'b0;
        tick();
        repeat (4) tick();

        // Sensor filter: one bad cycle is tolerated, two are a fault.
        set_tank(1'b1, 1'b0, 1'b1);
        tick();
        check("filter_1_no_fault", 8'(error), 8'd0);
        set_tank(1'b1, 1'b1, 1'b1);
        tick();
        set_tank(1'b1, 1'b1, 1'b0);
        tick();
        set_tank(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        check("filter_2_fault", 8'(state), 8'd4);
        ack = 1'b1;
        tick();
        check("ack_while_bad", 8'(state), 8'd4);
        set_tank(1'b1, 1'b1, 1'b0);
        tick();
        check("ack_when_good", 8'(state), 8'd0);
        ack = 1'b0;

        // Abort on low water, then reset during the refill.
        Us = 1'b1; T = 1'b0; Ua = 1'b1;
        tick();
        tick();
        set_tank(1'b1, 1'b0, 1'b0);
        tick();
        check("abort_fill", 8'(state), 8'd1);
        check("abort_valves", 8'({asp, got}), 8'd0);
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_ws_async", 8'(watter_supply), 8'd0);
        check("reset_state_async", 8'(state), 8'd0);
        tick();
        reset = 1'b0;
        set_tank(1'b1, 1'b1, 1'b0);
        Us = 1'b0;
        tick();

        // Randomized phase against the model.
        for (int i = 0; i < 800; i++) begin
            lvl = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                set_tank(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                set_tank(lvl >= 1, lvl >= 2, lvl >= 3);
            end
            Us  = ($urandom_range(0, 3) != 0);
            Ua  = 1'($urandom);
            T   = 1'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
